max_pool_2x2_stream: RTL and testbench

Streaming 2x2 / stride-2 max-pooling stage that sits directly downstream of the 2D convolution stage. It consumes the convolution's raster-order pixel stream (Valid/Out pair) for one IMG_Width x IMG_Height feature map. It emits a raster-order (IMG_Width/2) x (IMG_Height/2) pooled stream in the same Valid/data format, so it can feed the next convolution stage or an output FIFO. It uses one half-width line buffer of partial maxima and no frame buffer.

---
 rtl/max_pool_2x2_stream_if.sv | 21 ++
 rtl/max_pool_2x2_stream.sv | 97 +++++++++
 tb/tb_max_pool_2x2_stream.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_stream_if.sv
// Pixel stream bundle between the convolution stage and the 2x2 max-pool stage.
// The master drives the input pixels; the slave (the pooling stage) drives the pooled results.
interface max_pool_2x2_stream_if #(
   parameter int Datawidth = 16
);
   logic                 Valid_IN;
   logic [Datawidth-1:0] In;
   logic                 Valid_OUT;
   logic [Datawidth-1:0] Out;
   logic                 Frame_Done;

   modport master (
      output Valid_IN, In,
      input  Valid_OUT, Out, Frame_Done
   );

   modport slave (
      input  Valid_IN, In,
      output Valid_OUT, Out, Frame_Done
   );
endinterface

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool stage on a raster-order pixel stream.
// Uses one half-width line buffer of row-pair maxima and no frame buffer.
module max_pool_2x2_stream #(
   parameter int IMG_Width  = 28,
   parameter int IMG_Height = 28,
   parameter int Datawidth  = 16,
   parameter int Signed     = 1
) (
   input logic                   CLK,
   input logic                   CLR,
   max_pool_2x2_stream_if.slave  bus
);
   localparam int  HALF_W = IMG_Width / 2;
   localparam int  CW     = $clog2(IMG_Width);
   localparam int  HW     = $clog2(IMG_Height);
   localparam int  LBW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam bit  ODD_W  = (IMG_Width % 2) == 1;
   localparam bit  ODD_H  = (IMG_Height % 2) == 1;

   logic [CW-1:0]        cot;
   logic [HW-1:0]        hang;
   logic [Datawidth-1:0] pair;
   logic [Datawidth-1:0] line_buf [HALF_W];
   logic [Datawidth-1:0] out_q;
   logic                 valid_out_q;
   logic                 frame_done_q;

   logic                 last_col;
   logic                 last_row;
   logic                 in_pool;
   logic [LBW-1:0]       lb_idx;
   logic [Datawidth-1:0] pair_max;
   logic [Datawidth-1:0] window_max;

   function automatic logic [Datawidth-1:0] max2(input logic [Datawidth-1:0] a,
                                                 input logic [Datawidth-1:0] b);
      if (Signed != 0)
         return ($signed(a) >= $signed(b)) ? a : b;
      return (a >= b) ? a : b;
   endfunction

   // Trailing column/row of an odd-sized map is counted but never pooled.
   always_comb begin
      last_col   = (cot == CW'(IMG_Width - 1));
      last_row   = (hang == HW'(IMG_Height - 1));
      in_pool    = !(ODD_W && last_col) && !(ODD_H && last_row);
      lb_idx     = LBW'(cot >> 1);
      pair_max   = max2(pair, bus.In);
      window_max = max2(line_buf[lb_idx], pair_max);
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         cot          <= '0;
         hang         <= '0;
         pair         <= '0;
         out_q        <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (bus.Valid_IN) begin
            if (last_col) begin
               cot <= '0;
               if (last_row) begin
                  hang         <= '0;
                  frame_done_q <= 1'b1;
               end else begin
                  hang <= hang + 1'b1;
               end
            end else begin
               cot <= cot + 1'b1;
            end

            if (in_pool) begin
               if (!cot[0]) begin
                  pair <= bus.In;
               end else if (hang[0]) begin
                  out_q       <= window_max;
                  valid_out_q <= 1'b1;
               end
            end
         end
      end
   end

   // Even rows park their pair maxima here; the odd row below reads them back.
   always_ff @(posedge CLK) begin
      if (bus.Valid_IN && in_pool && cot[0] && !hang[0])
         line_buf[lb_idx] <= pair_max;
   end

   assign bus.Out        = out_q;
   assign bus.Valid_OUT  = valid_out_q;
   assign bus.Frame_Done = frame_done_q;
endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Scoreboard bench: three pooling stages (4x4 signed, 5x5 signed, 4x4 unsigned) share one
// input stream; a full-frame reference model predicts every pooled pixel and Frame_Done.
module tb_max_pool_2x2_stream;
   localparam int NDUT = 3;
   localparam int CFG_W [NDUT] = '{4, 5, 4};
   localparam int CFG_H [NDUT] = '{4, 5, 4};
   localparam bit CFG_S [NDUT] = '{1'b1, 1'b1, 1'b0};

   logic CLK = 1'b0;
   logic CLR;
   int   cycle = 0;

   max_pool_2x2_stream_if #(.Datawidth(16)) bus_a ();
   max_pool_2x2_stream_if #(.Datawidth(16)) bus_b ();
   max_pool_2x2_stream_if #(.Datawidth(16)) bus_c ();

   max_pool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16), .Signed(1)) dut_a (
      .CLK(CLK), .CLR(CLR), .bus(bus_a));
   max_pool_2x2_stream #(.IMG_Width(5), .IMG_Height(5), .Datawidth(16), .Signed(1)) dut_b (
      .CLK(CLK), .CLR(CLR), .bus(bus_b));
   max_pool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16), .Signed(0)) dut_c (
      .CLK(CLK), .CLR(CLR), .bus(bus_c));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cycle <= cycle + 1;

   logic        vout [NDUT];
   logic [15:0] dout [NDUT];
   logic        fdone [NDUT];
   assign vout[0] = bus_a.Valid_OUT;  assign dout[0] = bus_a.Out;  assign fdone[0] = bus_a.Frame_Done;
   assign vout[1] = bus_b.Valid_OUT;  assign dout[1] = bus_b.Out;  assign fdone[1] = bus_b.Frame_Done;
   assign vout[2] = bus_c.Valid_OUT;  assign dout[2] = bus_c.Out;  assign fdone[2] = bus_c.Frame_Done;

   typedef struct { int id; logic [15:0] val; int due; } out_exp_t;
   typedef struct { int id; int due; } fd_exp_t;
   out_exp_t    out_q [$];
   fd_exp_t     fd_q [$];
   logic [15:0] hold [NDUT];

   int          pos_c [NDUT];
   int          pos_h [NDUT];
   logic [15:0] img [NDUT][5][5];

   int tests_run = 0;
   int tests_failed = 0;

   task automatic checkOutput(input string name, input int k, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s dut%0d @cycle %0d: got 0x%0h expected 0x%0h", name, k, cycle, act, exp);
      end
   endtask

   function automatic logic [15:0] pick_max(input logic [15:0] a, input logic [15:0] b, input bit sg);
      if (sg) return ($signed(a) > $signed(b)) ? a : b;
      return (a > b) ? a : b;
   endfunction

   // Reference: keep the whole frame and take the max of each completed 2x2 window.
   task automatic model_accept(input int k, input logic [15:0] px, input int due);
      int c, h;
      logic [15:0] m;
      c = pos_c[k];
      h = pos_h[k];
      img[k][h][c] = px;
      if ((c % 2 == 1) && (h % 2 == 1) && (c < 2 * (CFG_W[k] / 2)) && (h < 2 * (CFG_H[k] / 2))) begin
         m = img[k][h-1][c-1];
         m = pick_max(m, img[k][h-1][c], CFG_S[k]);
         m = pick_max(m, img[k][h][c-1], CFG_S[k]);
         m = pick_max(m, img[k][h][c], CFG_S[k]);
         out_q.push_back('{id: k, val: m, due: due});
      end
      if (c == CFG_W[k] - 1) begin
         pos_c[k] = 0;
         if (h == CFG_H[k] - 1) begin
            pos_h[k] = 0;
            fd_q.push_back('{id: k, due: due});
         end else begin
            pos_h[k] = h + 1;
         end
      end else begin
         pos_c[k] = c + 1;
      end
   endtask

   task automatic set_inputs(input logic v, input logic [15:0] px);
      bus_a.Valid_IN = v;  bus_a.In = px;
      bus_b.Valid_IN = v;  bus_b.In = px;
      bus_c.Valid_IN = v;  bus_c.In = px;
   endtask

   // Pixel goes out at a falling edge and is captured at the next rising edge (cycle+1).
   task automatic applyStimulus(input logic [15:0] px, input int gap);
      repeat (gap) begin
         @(negedge CLK);
         bus_a.Valid_IN = 1'b0;  bus_b.Valid_IN = 1'b0;  bus_c.Valid_IN = 1'b0;
      end
      @(negedge CLK);
      set_inputs(1'b1, px);
      for (int k = 0; k < NDUT; k++) model_accept(k, px, cycle + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         bus_a.Valid_IN = 1'b0;  bus_b.Valid_IN = 1'b0;  bus_c.Valid_IN = 1'b0;
      end
   endtask

   // Reset lands between clock edges; outputs must clear without waiting for a clock.
   task automatic resetDuts();
      @(posedge CLK);
      #3;
      CLR = 1'b0;
      set_inputs(1'b0, 16'h0000);
      out_q.delete();
      fd_q.delete();
      for (int k = 0; k < NDUT; k++) begin
         pos_c[k] = 0;
         pos_h[k] = 0;
         hold[k]  = 16'h0000;
      end
      #1;
      for (int k = 0; k < NDUT; k++) begin
         checkOutput("reset_valid_out", k, int'(vout[k]), 0);
         checkOutput("reset_out", k, int'(dout[k]), 0);
         checkOutput("reset_frame_done", k, int'(fdone[k]), 0);
      end
      @(negedge CLK);
      @(negedge CLK);
      CLR = 1'b1;
   endtask

   function automatic int find_out(input int k);
      foreach (out_q[i]) if (out_q[i].id == k) return i;
      return -1;
   endfunction

   function automatic int find_fd(input int k);
      foreach (fd_q[i]) if (fd_q[i].id == k) return i;
      return -1;
   endfunction

   // Monitor: pops the oldest expectation of a stage whenever it presents a result.
   always @(negedge CLK) begin
      if (CLR) begin
         for (int k = 0; k < NDUT; k++) begin
            int idx;
            idx = find_out(k);
            if (vout[k]) begin
               if (idx < 0) begin
                  checkOutput("unexpected_valid_out", k, 1, 0);
               end else begin
                  checkOutput("out_value", k, int'(dout[k]), int'(out_q[idx].val));
                  checkOutput("out_cycle", k, cycle, out_q[idx].due);
                  hold[k] = out_q[idx].val;
                  out_q.delete(idx);
               end
            end else begin
               checkOutput("out_hold", k, int'(dout[k]), int'(hold[k]));
               if (idx >= 0 && out_q[idx].due <= cycle) begin
                  checkOutput("missing_valid_out", k, 0, 1);
                  out_q.delete(idx);
               end
            end

            idx = find_fd(k);
            if (fdone[k]) begin
               if (idx < 0) begin
                  checkOutput("unexpected_frame_done", k, 1, 0);
               end else begin
                  checkOutput("frame_done_cycle", k, cycle, fd_q[idx].due);
                  fd_q.delete(idx);
               end
            end else if (idx >= 0 && fd_q[idx].due <= cycle) begin
               checkOutput("missing_frame_done", k, 0, 1);
               fd_q.delete(idx);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int remaining;
      CLR = 1'b0;
      set_inputs(1'b0, 16'h0000);
      for (int k = 0; k < NDUT; k++) begin
         pos_c[k] = 0;
         pos_h[k] = 0;
         hold[k]  = 16'h0000;
      end
      repeat (2) @(negedge CLK);
      for (int k = 0; k < NDUT; k++) begin
         checkOutput("power_on_valid_out", k, int'(vout[k]), 0);
         checkOutput("power_on_out", k, int'(dout[k]), 0);
         checkOutput("power_on_frame_done", k, int'(fdone[k]), 0);
      end
      @(negedge CLK);
      CLR = 1'b1;

      $display("[TB] raster 0..15 on consecutive cycles");
      for (int i = 0; i < 16; i++) applyStimulus(16'(i), 0);
      idle(4);

      $display("[TB] raster 0..15 with input gaps");
      resetDuts();
      for (int i = 0; i < 16; i++) applyStimulus(16'(i), (i == 0) ? 0 : 1 + int'($urandom_range(0, 2)));
      idle(4);

      $display("[TB] raster 0..24 (odd 5x5 map)");
      resetDuts();
      for (int i = 0; i < 25; i++) applyStimulus(16'(i), 0);
      idle(4);

      $display("[TB] signed pattern with one -3 among -100");
      resetDuts();
      for (int i = 0; i < 16; i++) applyStimulus((i == 9) ? 16'hFFFD : 16'hFF9C, 0);
      idle(4);

      $display("[TB] unsigned pattern 0x0001 / 0xFFFD");
      resetDuts();
      for (int i = 0; i < 16; i++)
         applyStimulus((i == 0) ? 16'h0001 : ((i == 1) ? 16'hFFFD : 16'h0000), 0);
      idle(4);

      $display("[TB] back-to-back frames 0..15 then 15..0");
      resetDuts();
      for (int i = 0; i < 16; i++) applyStimulus(16'(i), 0);
      for (int i = 0; i < 16; i++) applyStimulus(16'(15 - i), 0);
      idle(4);

      $display("[TB] async reset mid-frame, then fresh frame");
      resetDuts();
      for (int i = 0; i < 7; i++) applyStimulus(16'(i), 0);
      resetDuts();
      for (int i = 0; i < 16; i++) applyStimulus(16'(i), 0);
      idle(4);

      $display("[TB] random pixels with random gaps");
      resetDuts();
      for (int i = 0; i < 100; i++)
         applyStimulus(16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      idle(6);

      for (int k = 0; k < NDUT; k++) begin
         remaining = 0;
         foreach (out_q[i]) if (out_q[i].id == k) remaining++;
         foreach (fd_q[i]) if (fd_q[i].id == k) remaining++;
         checkOutput("drain_pending", k, remaining, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
